// File: rtl/filter_result_store.sv
// Result sink for the 3x3 image filter: stores the filtered pixel stream into a
// raster-ordered frame buffer, tracks frame completion and keeps min/max/sum statistics.
module filter_result_store #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int DW    = 8,
  parameter int AW    = 12,
  parameter int SW    = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic          i_rd,
  input  logic [DW-1:0] i_cl_pixel,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  output logic          o_frame_done,
  output logic          o_overflow,
  output logic [AW:0]   o_pix_cnt,
  output logic [DW-1:0] o_pix_min,
  output logic [DW-1:0] o_pix_max,
  output logic [SW-1:0] o_pix_sum,
  output logic [1:0]    o_state
);

  localparam int DEPTH = IMG_W * IMG_H;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_take;
  logic          w_acc;
  logic          w_ovf_set;
  logic          w_last;
  logic          w_rd_ok;
  logic [AW-1:0] w_wr_addr;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [AW:0]   r_cnt;
  logic          r_ovf;
  logic [DW-1:0] r_min;
  logic [DW-1:0] r_max;
  logic [SW-1:0] r_sum;
  logic [DW-1:0] r_rd_data;
  logic [DW-1:0] r_mem [DEPTH];

  // A strobe is only meaningful with the filter enabled; clr always drops it.
  assign w_take    = i_en & i_rd & ~i_clr;
  assign w_last    = (r_row == RW'(IMG_H - 1)) && (r_col == CW'(IMG_W - 1));
  assign w_wr_addr = AW'(r_row) * AW'(IMG_W) + AW'(r_col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_acc     = 1'b0;
    w_ovf_set = 1'b0;
    case (r_state)
      S_IDLE, S_CAPTURE: begin
        if (w_take) begin
          w_acc  = 1'b1;
          w_next = w_last ? S_DONE : S_CAPTURE;
        end
      end
      S_DONE: begin
        if (w_take) begin
          w_ovf_set = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (i_clr) begin
      w_next = S_IDLE;
    end
  end

  // Frame buffer has no reset; read-before-write falls out of the non-blocking update.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_mem[w_wr_addr] <= i_cl_pixel;
    end
  end

  generate
    if (DEPTH < (1 << AW)) begin : g_rd_range
      assign w_rd_ok = (i_rd_addr < AW'(DEPTH));
    end else begin : g_rd_full
      assign w_rd_ok = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_ok ? r_mem[i_rd_addr] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_min <= '1;
      r_max <= '0;
      r_sum <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_min <= '1;
      r_max <= '0;
      r_sum <= '0;
    end else begin
      if (w_acc) begin
        if (r_col == CW'(IMG_W - 1)) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        r_cnt <= r_cnt + 1'b1;
        if (i_cl_pixel < r_min) begin
          r_min <= i_cl_pixel;
        end
        if (i_cl_pixel > r_max) begin
          r_max <= i_cl_pixel;
        end
        r_sum <= r_sum + SW'(i_cl_pixel);
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign o_rd_data    = r_rd_data;
  assign o_frame_done = (r_state == S_DONE);
  assign o_overflow   = r_ovf;
  assign o_pix_cnt    = r_cnt;
  assign o_pix_min    = r_min;
  assign o_pix_max    = r_max;
  assign o_pix_sum    = r_sum;
  assign o_state      = r_state;

endmodule

// File: tb/tb_filter_result_store.sv
// Bench for filter_result_store: directed frames with hand-computed expectations;
// read responses are checked by a monitor against an expected queue.
module tb_filter_result_store;

  localparam int DW = 8;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          clr;
  logic          rd;
  logic [DW-1:0] cl_pixel;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          frame_done;
  logic          overflow;
  logic [AW:0]   pix_cnt;
  logic [DW-1:0] pix_min;
  logic [DW-1:0] pix_max;
  logic [19:0]   pix_sum;
  logic [1:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;
  logic          rd_req;
  logic          rd_req_q;

  filter_result_store dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (en),
    .i_clr        (clr),
    .i_rd         (rd),
    .i_cl_pixel   (cl_pixel),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_frame_done (frame_done),
    .o_overflow   (overflow),
    .o_pix_cnt    (pix_cnt),
    .o_pix_min    (pix_min),
    .o_pix_max    (pix_max),
    .o_pix_sum    (pix_sum),
    .o_state      (state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  // A read request issued before an edge has its data valid after that edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_req_q <= 1'b0;
    else        rd_req_q <= rd_req;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rd_req_q) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_data: got %02h with no expected value queued", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data !== mon_exp) begin
          n_fail++;
          $display("FAIL rd_data: got %02h expected %02h", rd_data, mon_exp);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] pix);
    en       = 1'b1;
    rd       = 1'b1;
    cl_pixel = pix;
    tick();
    rd       = 1'b0;
  endtask

  task automatic read_req(input logic [AW-1:0] a, input logic [DW-1:0] e);
    rd_addr = a;
    rd_req  = 1'b1;
    exp_q.push_back(e);
    tick();
    rd_req  = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic check_stats(input string tag, input int cnt, input int mn, input int mx,
                             input int sum, input int done, input int ovf);
    check({tag, " pix_cnt"},    32'(pix_cnt),    cnt);
    check({tag, " pix_min"},    32'(pix_min),    mn);
    check({tag, " pix_max"},    32'(pix_max),    mx);
    check({tag, " pix_sum"},    32'(pix_sum),    sum);
    check({tag, " frame_done"}, 32'(frame_done), done);
    check({tag, " overflow"},   32'(overflow),   ovf);
  endtask

  logic [DW-1:0] acc_vals[$];
  int            acc_sum;
  int            acc_min;
  int            acc_max;

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    clr      = 1'b0;
    rd       = 1'b0;
    cl_pixel = '0;
    rd_addr  = '0;
    rd_req   = 1'b0;
    repeat (2) tick();

    // Reset values
    check_stats("reset", 0, 255, 0, 0, 0, 0);
    check("reset rd_data", 32'(rd_data), 0);
    check("reset state",   32'(state),   0);
    rst_n = 1'b1;
    tick();

    // Row wrap: values 1..65
    for (int i = 1; i <= 65; i++) send(8'(i));
    check_stats("wrap", 65, 1, 65, 2145, 0, 0);
    check("wrap state", 32'(state), 1);
    read_req(12'd63, 8'd64);
    read_req(12'd64, 8'd65);
    read_req(12'd0,  8'd1);

    pulse_clr();
    check_stats("clr1", 0, 255, 0, 0, 0, 0);
    check("clr1 state", 32'(state), 0);

    // Full ramp frame
    for (int i = 0; i < 4095; i++) send(8'(i % 256));
    check("ramp pre-last pix_cnt",    32'(pix_cnt),    4095);
    check("ramp pre-last frame_done", 32'(frame_done), 0);
    send(8'd255);
    check_stats("ramp", 4096, 0, 255, 522240, 1, 0);
    check("ramp state", 32'(state), 2);
    read_req(12'd65,   8'd65);
    read_req(12'd300,  8'd44);
    read_req(12'd4095, 8'd255);
    read_req(12'd0,    8'd0);

    // Overflow: rd with en=0 in DONE is ignored, rd with en=1 is flagged
    en = 1'b0; rd = 1'b1; cl_pixel = 8'hAA;
    tick();
    rd = 1'b0; en = 1'b1;
    check("ovf en0 overflow", 32'(overflow), 0);
    send(8'hAA);
    check_stats("ovf", 4096, 0, 255, 522240, 1, 1);
    read_req(12'd0,    8'd0);
    read_req(12'd4095, 8'd255);

    // clr colliding with rd at pixel 100
    pulse_clr();
    for (int i = 0; i < 100; i++) send(8'(i + 10));
    clr = 1'b1; rd = 1'b1; cl_pixel = 8'h77;
    tick();
    clr = 1'b0; rd = 1'b0;
    check_stats("clrrd", 0, 255, 0, 0, 0, 0);
    check("clrrd state", 32'(state), 0);
    // Same-cycle read of the address being written returns the old contents.
    rd_addr = '0;
    rd_req  = 1'b1;
    exp_q.push_back(8'd10);
    send(8'h33);
    rd_req  = 1'b0;
    check_stats("clrrd next", 1, 8'h33, 8'h33, 8'h33, 0, 0);
    read_req(12'd0,   8'h33);
    read_req(12'd50,  8'd60);
    read_req(12'd100, 8'd100);

    // Gaps and pause: rd every third cycle, en low for 10 cycles with rd toggling
    pulse_clr();
    acc_vals.delete();
    acc_sum = 0; acc_min = 255; acc_max = 0;
    for (int c = 0; c < 60; c++) begin
      en       = !(c >= 20 && c < 30);
      rd       = (c >= 20 && c < 30) ? 1'(c % 2) : (c % 3 == 0);
      cl_pixel = 8'(100 + c);
      if (en && rd) begin
        acc_vals.push_back(cl_pixel);
        acc_sum += int'(cl_pixel);
        if (int'(cl_pixel) < acc_min) acc_min = int'(cl_pixel);
        if (int'(cl_pixel) > acc_max) acc_max = int'(cl_pixel);
      end
      tick();
    end
    rd = 1'b0; en = 1'b1;
    check_stats("gaps", acc_vals.size(), acc_min, acc_max, acc_sum, 0, 0);
    for (int k = 0; k < acc_vals.size(); k++) read_req(AW'(k), acc_vals[k]);
    read_req(AW'(acc_vals.size()), 8'(acc_vals.size() + 10));

    // Async reset between edges at pixel 2000
    pulse_clr();
    for (int i = 0; i < 2000; i++) send(8'(i * 7));
    #2;
    rst_n = 1'b0;
    #1;
    check_stats("async", 0, 255, 0, 0, 0, 0);
    check("async rd_data", 32'(rd_data), 0);
    check("async state",   32'(state),   0);
    #2;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4095; i++) send(8'h10);
    check("refill pre-last frame_done", 32'(frame_done), 0);
    send(8'h10);
    check_stats("refill", 4096, 16, 16, 65536, 1, 0);
    read_req(12'd2000, 8'h10);
    read_req(12'd4095, 8'h10);

    repeat (3) tick();
    check("scoreboard drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
